// File: rtl/bf_ffunc_seq.sv
// bf_ffunc_seq
//    Blowfish F-function sequencer. Computes
//       F(xl) = ((S0[a] + S1[b]) ^ S2[c]) + S3[d]   (mod 2^32)
//    by issuing the four S-box lookups one after another on a single shared
//    lookup port. Only one evaluation is in flight at a time.
//
// Parameters
//    SBOX_LAT    lookup-port latency: 0 = combinational bank, 1 = registered bank
//    BYTE_ORDER  0: a = xl[31:24] .. d = xl[7:0];  1: a = xl[7:0] .. d = xl[31:24]
//
// Ports
//    clk        clock, rising edge
//    rst        synchronous active-high reset
//    in_valid   upstream offers xl
//    in_ready   block can accept xl (IDLE only)
//    xl         F-function input half-block
//    sbox_sel   S-box select (0..3) for the lookup port
//    sbox_idx   byte index into the selected S-box
//    sbox_data  S-box word returned for (sbox_sel, sbox_idx)
//    out_valid  f_out is valid
//    out_ready  downstream accepts f_out
//    f_out      F(xl) result
//    busy       high in every state except IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for xl; in_ready high
// LK0   | lookup S0[a]; acc <= data
// LK1   | lookup S1[b]; acc <= acc + data
// LK2   | lookup S2[c]; acc <= acc ^ data
// LK3   | lookup S3[d]; f_out <= acc + data
// DONE  | out_valid high; f_out held until out_ready

module bf_ffunc_seq #(
   parameter int SBOX_LAT   = 0,
   parameter int BYTE_ORDER = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] xl,
   output logic [1:0]  sbox_sel,
   output logic [7:0]  sbox_idx,
   input  logic [31:0] sbox_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] f_out,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LK0  = 3'd1,
      LK1  = 3'd2,
      LK2  = 3'd3,
      LK3  = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] xl_r;
   logic [31:0] acc;
   logic        ph;      // second cycle of a lookup when the bank is registered
   logic        step;    // sbox_data is valid this cycle: consume it and advance
   logic [1:0]  sel_nxt;

   // Byte k of a word, k = 0 is the 'a' byte.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
      logic [1:0] pos;
      pos = (BYTE_ORDER == 0) ? (2'd3 - k) : k;
      case (pos)
         2'd0:    byte_of = w[7:0];
         2'd1:    byte_of = w[15:8];
         2'd2:    byte_of = w[23:16];
         default: byte_of = w[31:24];
      endcase
   endfunction

   // A registered bank answers one cycle after sel/idx change, so each
   // lookup is held for two cycles and sampled in the second.
   assign step    = (SBOX_LAT == 0) ? 1'b1 : ph;
   assign sel_nxt = sbox_sel + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = LK0;
         end
         LK0: if (step) state_nxt = LK1;
         LK1: if (step) state_nxt = LK2;
         LK2: if (step) state_nxt = LK3;
         LK3: if (step) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // sel/idx are registers so the bank never sees a combinational path from
   // xl, and they keep their last value in IDLE and DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         xl_r     <= '0;
         acc      <= '0;
         f_out    <= '0;
         ph       <= 1'b0;
         sbox_sel <= '0;
         sbox_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xl_r     <= xl;
                  ph       <= 1'b0;
                  sbox_sel <= 2'd0;
                  sbox_idx <= byte_of(xl, 2'd0);
               end
            end
            LK0, LK1, LK2, LK3: begin
               if (!step) begin
                  ph <= 1'b1;
               end else begin
                  ph <= 1'b0;
                  case (state)
                     LK0:     acc   <= sbox_data;
                     LK1:     acc   <= acc + sbox_data;
                     LK2:     acc   <= acc ^ sbox_data;
                     default: f_out <= acc + sbox_data;
                  endcase
                  if (state != LK3) begin
                     sbox_sel <= sel_nxt;
                     sbox_idx <= byte_of(xl_r, sel_nxt);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bf_ffunc_seq.sv
module tb_bf_ffunc_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // u0: SBOX_LAT=0, BYTE_ORDER=0 ; u1: SBOX_LAT=1 ; u2: BYTE_ORDER=1
   logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
   logic [31:0] xl0, data0, f_out0;
   logic [1:0]  sel0;
   logic [7:0]  idx0;
   logic        stub_ff;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [31:0] xl1, data1, f_out1;
   logic [1:0]  sel1;
   logic [7:0]  idx1;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [31:0] xl2, data2, f_out2;
   logic [1:0]  sel2;
   logic [7:0]  idx2;

   assign data0 = stub_ff ? 32'hFFFF_FFFF : {6'd0, sel0, 16'd0, idx0};
   always_ff @(posedge clk) data1 <= {6'd0, sel1, 16'd0, idx1};
   assign data2 = {6'd0, sel2, 16'd0, idx2};

   bf_ffunc_seq #(.SBOX_LAT(0), .BYTE_ORDER(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .xl(xl0),
      .sbox_sel(sel0), .sbox_idx(idx0), .sbox_data(data0), .out_valid(out_valid0),
      .out_ready(out_ready0), .f_out(f_out0), .busy(busy0));

   bf_ffunc_seq #(.SBOX_LAT(1), .BYTE_ORDER(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .xl(xl1),
      .sbox_sel(sel1), .sbox_idx(idx1), .sbox_data(data1), .out_valid(out_valid1),
      .out_ready(out_ready1), .f_out(f_out1), .busy(busy1));

   bf_ffunc_seq #(.SBOX_LAT(0), .BYTE_ORDER(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .xl(xl2),
      .sbox_sel(sel2), .sbox_idx(idx2), .sbox_data(data2), .out_valid(out_valid2),
      .out_ready(out_ready2), .f_out(f_out2), .busy(busy2));

   logic [7:0] idx_fwd [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] idx_rev [4] = '{8'h04, 8'h03, 8'h02, 8'h01};

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready0 !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready0); end
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
      checks++; if (busy0 !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      checks++; if (f_out0 !== 32'h0)    begin failures++; $display("FAIL reset_f_out got=%h exp=00000000", f_out0); end
      checks++; if (sel0 !== 2'd0 || idx0 !== 8'h00) begin failures++; $display("FAIL reset_sel_idx got=%0d/%h exp=0/00", sel0, idx0); end
      checks++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_lat1 got=%b/%b exp=1/0", in_ready1, busy1); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      stub_ff = 1'b0; out_ready0 = 1'b1;
      @(negedge clk);
      xl0 = 32'h0102_0304; in_valid0 = 1'b1;
      checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", in_ready0); end
      @(negedge clk);
      in_valid0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (sel0 !== 2'(k) || idx0 !== idx_fwd[k]) begin failures++; $display("FAIL basic_lookup%0d got=%0d/%h exp=%0d/%h", k, sel0, idx0, k, idx_fwd[k]); end
         checks++; if (out_valid0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy%0d got=%b/%b exp=0/1", k, out_valid0, busy0); end
         @(negedge clk);
      end
      checks++; if (out_valid0 !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid0); end
      checks++; if (f_out0 !== 32'h0600_0004) begin failures++; $display("FAIL basic_f_out got=%h exp=06000004", f_out0); end
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin failures++; $display("FAIL basic_release got=%b/%b exp=0/1", out_valid0, in_ready0); end
   endtask

   task automatic test_wrap();
      stub_ff = 1'b1; out_ready0 = 1'b1;
      xl0 = 32'hA5A5_5A5A; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (out_valid0 !== 1'b1 || f_out0 !== 32'h0) begin failures++; $display("FAIL wrap_f_out got=%b/%h exp=1/00000000", out_valid0, f_out0); end
      @(negedge clk);
      stub_ff = 1'b0;
   endtask

   task automatic test_backpressure();
      out_ready0 = 1'b0;
      xl0 = 32'h0102_0304; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         in_valid0 = 1'b1; xl0 = 32'hDEAD_BEEF;
         checks++; if (out_valid0 !== 1'b1 || f_out0 !== 32'h0600_0004) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/06000004", i, out_valid0, f_out0); end
         checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready0); end
         @(negedge clk);
      end
      in_valid0 = 1'b0; out_ready0 = 1'b1;
      checks++; if (out_valid0 !== 1'b1 || f_out0 !== 32'h0600_0004) begin failures++; $display("FAIL bp_hold_last got=%b/%h exp=1/06000004", out_valid0, f_out0); end
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin failures++; $display("FAIL bp_release got=%b/%b exp=0/1", out_valid0, in_ready0); end
      @(negedge clk);
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL bp_not_accepted got=%b exp=0", busy0); end
   endtask

   task automatic test_lat1();
      out_ready1 = 1'b1;
      xl1 = 32'h0102_0304; in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++; if (sel1 !== 2'(k / 2) || idx1 !== idx_fwd[k / 2]) begin failures++; $display("FAIL lat1_lookup%0d got=%0d/%h exp=%0d/%h", k, sel1, idx1, k / 2, idx_fwd[k / 2]); end
         checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL lat1_early_valid%0d got=%b exp=0", k, out_valid1); end
         @(negedge clk);
      end
      checks++; if (out_valid1 !== 1'b1 || f_out1 !== 32'h0600_0004) begin failures++; $display("FAIL lat1_f_out got=%b/%h exp=1/06000004", out_valid1, f_out1); end
      @(negedge clk);
      checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL lat1_release got=%b exp=1", in_ready1); end
   endtask

   task automatic test_midreset();
      out_ready0 = 1'b1;
      xl0 = 32'h0102_0304; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (sel0 !== 2'd2) begin failures++; $display("FAIL mid_in_lk2 got=%0d exp=2", sel0); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b/%b exp=1/0", in_ready0, busy0); end
      checks++; if (out_valid0 !== 1'b0 || f_out0 !== 32'h0) begin failures++; $display("FAIL mid_clear got=%b/%h exp=0/00000000", out_valid0, f_out0); end
      for (int n = 0; n < 6; n++) begin
         checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL mid_no_partial%0d got=%b exp=0", n, out_valid0); end
         @(negedge clk);
      end
      xl0 = 32'h0102_0304; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (out_valid0 !== 1'b1 || f_out0 !== 32'h0600_0004) begin failures++; $display("FAIL mid_rerun got=%b/%h exp=1/06000004", out_valid0, f_out0); end
      @(negedge clk);
   endtask

   task automatic test_byte_order();
      out_ready2 = 1'b1;
      xl2 = 32'h0102_0304; in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++; if (sel2 !== 2'(k) || idx2 !== idx_rev[k]) begin failures++; $display("FAIL bo_lookup%0d got=%0d/%h exp=%0d/%h", k, sel2, idx2, k, idx_rev[k]); end
         @(negedge clk);
      end
      // 00000004 + 01000003 = 01000007; ^ 02000002 = 03000005; + 03000001 = 06000006
      checks++; if (out_valid2 !== 1'b1 || f_out2 !== 32'h0600_0006) begin failures++; $display("FAIL bo_f_out got=%b/%h exp=1/06000006", out_valid2, f_out2); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready0 = 1'b1;
      xl0 = 32'h0102_0304; in_valid0 = 1'b1;
      @(negedge clk);
      repeat (4) @(negedge clk);
      checks++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b/%b exp=1/0", out_valid0, in_ready0); end
      @(negedge clk);
      checks++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=1/0", in_ready0, out_valid0); end
      @(negedge clk);
      in_valid0 = 1'b0;
      checks++; if (busy0 !== 1'b1 || sel0 !== 2'd0 || idx0 !== 8'h01) begin failures++; $display("FAIL b2b_accept got=%b/%0d/%h exp=1/0/01", busy0, sel0, idx0); end
      repeat (4) @(negedge clk);
      checks++; if (out_valid0 !== 1'b1 || f_out0 !== 32'h0600_0004) begin failures++; $display("FAIL b2b_f_out got=%b/%h exp=1/06000004", out_valid0, f_out0); end
      @(negedge clk);
      checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b exp=1", in_ready0); end
   endtask

   initial begin
      rst = 1'b1; stub_ff = 1'b0;
      in_valid0 = 1'b0; out_ready0 = 1'b1; xl0 = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; xl1 = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; xl2 = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_lat1();
      test_midreset();
      test_byte_order();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
